// File: rtl/dump_pkg.sv
// Shared types and constants for the state dump engine: FSM encoding and the
// fixed layout of the four header words that open every dump record.
package dump_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HDR,
      ST_REG,
      ST_MEM
   } dump_state_t;

   localparam int HDR_CYCLE = 0;
   localparam int HDR_STALL = 1;
   localparam int HDR_FLUSH = 2;
   localparam int HDR_PC    = 3;
   localparam int HDR_WORDS = 4;

endpackage

// File: rtl/sat_counter32.sv
// 32-bit event counter that advances on an enable and sticks at all-ones
// instead of wrapping, so a long run never reports a small count.
module sat_counter32 (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        inc_i,
   output logic [31:0] count_o
);

   // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         count_o <= '0;
      end else if (inc_i && (count_o != 32'hFFFF_FFFF)) begin
         count_o <= count_o + 32'd1;
      end
   end

endmodule

// File: rtl/state_dump_engine.sv
// Streams a debug record (counter/PC snapshot, register file, data memory)
// over a valid/ready port at one word per cycle, reading RF/DM live.
module state_dump_engine
   import dump_pkg::*;
#(
   parameter int NUM_REGS      = 32,
   parameter int NUM_MEM_WORDS = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] pc_i,
   input  logic        dump_req_i,
   output logic [4:0]  rf_addr_o,
   input  logic [31:0] rf_data_i,
   output logic [31:0] dm_addr_o,
   input  logic [31:0] dm_data_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] out_data_o,
   output logic        out_last_o,
   output logic        busy_o,
   output logic        overrun_o
);

   localparam int REC_LEN  = HDR_WORDS + NUM_REGS + NUM_MEM_WORDS;
   localparam int MEM_BASE = HDR_WORDS + NUM_REGS;
   localparam int IDX_W    = $clog2(REC_LEN + 1);

   typedef logic [IDX_W-1:0] idx_t;

   dump_state_t state, state_next;
   idx_t        idx, idx_next, nidx;
   logic        load, accept;
   logic [31:0] word_next;
   logic [31:0] cycle_cnt, stall_cnt, flush_cnt;
   logic [31:0] snap_stall, snap_flush, snap_pc;

   sat_counter32 u_cycle_cnt (.clk_i(clk_i), .rst_i(rst_i), .inc_i(start_i), .count_o(cycle_cnt));
   sat_counter32 u_stall_cnt (.clk_i(clk_i), .rst_i(rst_i), .inc_i(stall_i), .count_o(stall_cnt));
   sat_counter32 u_flush_cnt (.clk_i(clk_i), .rst_i(rst_i), .inc_i(flush_i), .count_o(flush_cnt));

   // Which section of the record a word index belongs to.
   function automatic dump_state_t region_of(idx_t k);
      if (k < idx_t'(HDR_WORDS)) begin
         return ST_HDR;
      end else if (k < idx_t'(MEM_BASE)) begin
         return ST_REG;
      end
      return ST_MEM;
   endfunction

   assign accept      = (state == ST_IDLE) && dump_req_i;
   assign out_valid_o = (state != ST_IDLE);
   assign busy_o      = (state != ST_IDLE);

   // Addresses always point at the word after the one on display, so the
   // handshake edge can load it with no bubble; they hold while stalled.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path infers a latch.
      nidx      = idx + idx_t'(1);
      rf_addr_o = '0;
      dm_addr_o = '0;
      word_next = out_data_o;
      if ((state != ST_IDLE) && (nidx < idx_t'(REC_LEN))) begin
         case (region_of(nidx))
            ST_HDR: begin
               case (int'(nidx))
                  HDR_STALL: word_next = snap_stall;
                  HDR_FLUSH: word_next = snap_flush;
                  default:   word_next = snap_pc;
               endcase
            end
            ST_REG: begin
               rf_addr_o = 5'(nidx - idx_t'(HDR_WORDS));
               word_next = rf_data_i;
            end
            default: begin
               dm_addr_o = 32'(nidx - idx_t'(MEM_BASE)) << 2;
               word_next = dm_data_i;
            end
         endcase
      end
   end

   always_comb begin
      state_next = state;
      idx_next   = idx;
      load       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (dump_req_i) begin
               state_next = ST_HDR;
               idx_next   = idx_t'(HDR_CYCLE);
               load       = 1'b1;
            end
         end
         default: begin
            if (out_ready_i) begin
               if (idx == idx_t'(REC_LEN - 1)) begin
                  state_next = ST_IDLE;
               end else begin
                  state_next = region_of(nidx);
                  idx_next   = nidx;
                  load       = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         idx        <= '0;
         out_data_o <= '0;
         out_last_o <= 1'b0;
         overrun_o  <= 1'b0;
         snap_stall <= '0;
         snap_flush <= '0;
         snap_pc    <= '0;
      end else begin
         idx <= idx_next;
         if (load) begin
            // k0 comes straight from the live counter: it equals the snapshot.
            out_data_o <= accept ? cycle_cnt : word_next;
            out_last_o <= (idx_next == idx_t'(REC_LEN - 1));
         end else if (out_ready_i) begin
            out_last_o <= 1'b0;
         end
         if (accept) begin
            snap_stall <= stall_cnt;
            snap_flush <= flush_cnt;
            snap_pc    <= pc_i;
         end
         if (dump_req_i && (state != ST_IDLE)) begin
            overrun_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_state_dump_engine.sv
// Self-checking bench for state_dump_engine: directed record checks plus a
// randomized run scored against a transaction-level model of the record.
module tb_state_dump_engine;
   import dump_pkg::*;

   localparam int NREG = 32;
   localparam int NMEM = 8;
   localparam int L    = HDR_WORDS + NREG + NMEM;

   typedef struct {
      string       name;
      int          k;
      logic [31:0] exp;
   } vec_t;

   logic        clk_i       = 1'b0;
   logic        rst_i       = 1'b0;
   logic        start_i     = 1'b0;
   logic        stall_i     = 1'b0;
   logic        flush_i     = 1'b0;
   logic        dump_req_i  = 1'b0;
   logic        out_ready_i = 1'b0;
   logic [31:0] pc_i        = '0;
   logic [4:0]  rf_addr_o;
   logic [31:0] rf_data_i, dm_addr_o, dm_data_i, out_data_o;
   logic        out_valid_o, out_last_o, busy_o, overrun_o;

   logic [31:0] rf_mem [NREG];
   logic [31:0] dm_mem [NMEM];

   int checks = 0;
   int errors = 0;

   // Record-level model state.
   logic [31:0] m_cyc = '0, m_stall = '0, m_flush = '0;
   logic [31:0] hdr [HDR_WORDS];
   logic [31:0] exp_cur = '0;
   bit          m_busy = 1'b0, m_overrun = 1'b0;
   int          m_k = 0;
   int          handshakes = 0;
   logic [31:0] got [64];

   state_dump_engine #(.NUM_REGS(NREG), .NUM_MEM_WORDS(NMEM)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
      .flush_i(flush_i), .pc_i(pc_i), .dump_req_i(dump_req_i),
      .rf_addr_o(rf_addr_o), .rf_data_i(rf_data_i),
      .dm_addr_o(dm_addr_o), .dm_data_i(dm_data_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_data_o(out_data_o), .out_last_o(out_last_o),
      .busy_o(busy_o), .overrun_o(overrun_o)
   );

   always #5 clk_i = ~clk_i;

   assign rf_data_i = rf_mem[rf_addr_o];
   assign dm_data_i = (dm_addr_o < 32'(4 * NMEM)) ? dm_mem[dm_addr_o[4:2]] : 32'hDEAD_BEEF;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   function automatic logic [31:0] sat_inc(logic [31:0] v, logic en);
      return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
   endfunction

   function automatic vec_t mkv(string n, int k, logic [31:0] e);
      vec_t v;
      v.name = n;
      v.k    = k;
      v.exp  = e;
      return v;
   endfunction

   // Word k as the record defines it, read from the bench's RF/DM right now.
   function automatic logic [31:0] exp_word(int k);
      if (k < HDR_WORDS)        return hdr[k];
      if (k < HDR_WORDS + NREG) return rf_mem[5'(k - HDR_WORDS)];
      return dm_mem[3'(k - HDR_WORDS - NREG)];
   endfunction

   // One clock: score the word on display, advance the model with the
   // inputs present at the edge, then check handshake-level outputs.
   task automatic cycle();
      bit hs;
      int nk;
      hs = m_busy && out_ready_i;
      nk = m_k + 1;
      if (m_busy) begin
         check("data", out_data_o, exp_cur);
         check1("last", out_last_o, m_k == L - 1);
         if (nk >= HDR_WORDS && nk < HDR_WORDS + NREG)
            check("rf_addr", 32'(rf_addr_o), 32'(nk - HDR_WORDS));
         else if (nk >= HDR_WORDS + NREG && nk < L)
            check("dm_addr", dm_addr_o, 32'(4 * (nk - HDR_WORDS - NREG)));
      end else begin
         check("idle_rf_addr", 32'(rf_addr_o), 32'd0);
         check("idle_dm_addr", dm_addr_o, 32'd0);
      end
      if (m_busy) begin
         if (dump_req_i) m_overrun = 1'b1;
         if (hs) begin
            got[6'(m_k)] = out_data_o;
            handshakes++;
            if (m_k == L - 1) begin
               m_busy = 1'b0;
            end else begin
               m_k     = nk;
               exp_cur = exp_word(m_k);
            end
         end
      end else if (dump_req_i) begin
         hdr[HDR_CYCLE] = m_cyc;
         hdr[HDR_STALL] = m_stall;
         hdr[HDR_FLUSH] = m_flush;
         hdr[HDR_PC]    = pc_i;
         m_k     = 0;
         exp_cur = m_cyc;
         m_busy  = 1'b1;
      end
      m_cyc   = sat_inc(m_cyc, start_i);
      m_stall = sat_inc(m_stall, stall_i);
      m_flush = sat_inc(m_flush, flush_i);
      @(posedge clk_i);
      #1;
      check1("valid", out_valid_o, m_busy);
      check1("busy", busy_o, m_busy);
      check1("overrun", overrun_o, m_overrun);
   endtask

   task automatic run_to_idle(input int budget, output int n);
      n = 0;
      while (m_busy && n < budget) begin
         cycle();
         n++;
      end
      check1("drain_timeout", m_busy, 1'b0);
   endtask

   task automatic request();
      dump_req_i = 1'b1;
      cycle();
      dump_req_i = 1'b0;
   endtask

   // Asserts reset mid-cycle, checks the immediate effect, releases after an edge.
   task automatic do_reset();
      #2 rst_i = 1'b0;
      #1;
      check1("rst_valid", out_valid_o, 1'b0);
      check1("rst_busy", busy_o, 1'b0);
      check1("rst_last", out_last_o, 1'b0);
      check1("rst_overrun", overrun_o, 1'b0);
      check("rst_data", out_data_o, 32'd0);
      m_cyc = '0; m_stall = '0; m_flush = '0;
      m_busy = 1'b0; m_overrun = 1'b0;
      @(posedge clk_i);
      #1 rst_i = 1'b1;
   endtask

   initial begin
      vec_t vecs[13];
      int   n, h0;
      bit   sent;
      bit   pat[4];

      for (int i = 0; i < NREG; i++) rf_mem[i] = 32'h1000 + 32'(i);
      rf_mem[0]  = 32'd0;
      rf_mem[24] = 32'hFFFF_FFE8;
      rf_mem[31] = 32'd62;
      for (int j = 0; j < NMEM; j++) dm_mem[j] = 32'h100 + 32'(j);
      dm_mem[0] = 32'd5; dm_mem[1] = 32'd6; dm_mem[2] = 32'd10;
      dm_mem[3] = 32'd18; dm_mem[4] = 32'd29;

      vecs[0]  = mkv("k0_cycle", 0, 32'd10);
      vecs[1]  = mkv("k1_stall", 1, 32'd3);
      vecs[2]  = mkv("k2_flush", 2, 32'd2);
      vecs[3]  = mkv("k3_pc", 3, 32'h0000_0100);
      vecs[4]  = mkv("k4_x0", 4, 32'd0);
      vecs[5]  = mkv("k28_x24", 28, 32'hFFFF_FFE8);
      vecs[6]  = mkv("k35_x31", 35, 32'd62);
      vecs[7]  = mkv("k36_dm0", 36, 32'd5);
      vecs[8]  = mkv("k37_dm1", 37, 32'd6);
      vecs[9]  = mkv("k38_dm2", 38, 32'd10);
      vecs[10] = mkv("k39_dm3", 39, 32'd18);
      vecs[11] = mkv("k40_dm4", 40, 32'd29);
      vecs[12] = mkv("k43_dm7", 43, 32'h107);

      // Reset values while held in reset.
      #3;
      check1("por_valid", out_valid_o, 1'b0);
      check1("por_busy", busy_o, 1'b0);
      check1("por_overrun", overrun_o, 1'b0);
      check("por_data", out_data_o, 32'd0);
      @(posedge clk_i);
      #1 rst_i = 1'b1;

      // 10 run cycles with 3 stalls and 2 flushes, then a request.
      start_i = 1'b1;
      for (int c = 0; c < 10; c++) begin
         stall_i = (c == 1 || c == 3 || c == 5);
         flush_i = (c == 2 || c == 6);
         cycle();
      end
      stall_i = 1'b0; flush_i = 1'b0; start_i = 1'b0;
      pc_i = 32'h0000_0100;
      out_ready_i = 1'b1;
      request();
      check1("req_latency_valid", out_valid_o, 1'b1);
      check("req_latency_k0", out_data_o, 32'd10);
      // Events during the dump must not reach the emitted header.
      n = 0;
      while (m_busy && n < 200) begin
         start_i = 1'b1;
         stall_i = (n % 5 == 0);
         flush_i = (n % 7 == 0);
         cycle();
         n++;
      end
      stall_i = 1'b0; flush_i = 1'b0;
      check("consecutive_cycles", 32'(n), 32'(L));
      for (int i = 0; i < 13; i++) check(vecs[i].name, got[6'(vecs[i].k)], vecs[i].exp);
      cycle();

      // Ready pattern 1,0,0,1: nothing lost or duplicated, words held in stalls.
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      h0 = handshakes;
      pc_i = 32'hCAFE_0000;
      request();
      n = 0;
      while (m_busy && n < 400) begin
         out_ready_i = pat[n % 4];
         cycle();
         n++;
      end
      check("toggle_words", 32'(handshakes - h0), 32'(L));
      out_ready_i = 1'b1;
      cycle();

      // Second request at word 10 is dropped and flagged.
      h0 = handshakes;
      sent = 1'b0;
      request();
      n = 0;
      while (m_busy && n < 200) begin
         dump_req_i = (m_k == 10) && !sent;
         if (dump_req_i) sent = 1'b1;
         cycle();
         n++;
      end
      dump_req_i = 1'b0;
      check1("overrun_set", overrun_o, 1'b1);
      check("overrun_words", 32'(handshakes - h0), 32'(L));
      repeat (3) cycle();
      check1("overrun_held", overrun_o, 1'b1);

      // Reset at word 20 abandons the record; a new request gives a full one.
      start_i = 1'b0;
      request();
      n = 0;
      while (m_busy && m_k < 20 && n < 100) begin
         cycle();
         n++;
      end
      do_reset();
      repeat (4) cycle();
      h0 = handshakes;
      request();
      check("post_rst_k0", out_data_o, 32'd0);
      run_to_idle(200, n);
      check("post_rst_words", 32'(handshakes - h0), 32'(L));

      // Randomized traffic against the model.
      for (int c = 0; c < 1500; c++) begin
         int ri, di;
         start_i     = ($urandom_range(0, 3) != 0);
         stall_i     = ($urandom_range(0, 3) == 0);
         flush_i     = ($urandom_range(0, 5) == 0);
         out_ready_i = ($urandom_range(0, 9) < 7);
         dump_req_i  = ($urandom_range(0, 15) == 0);
         pc_i        = $urandom;
         ri = int'($urandom_range(0, NREG - 1));
         di = int'($urandom_range(0, NMEM - 1));
         if ($urandom_range(0, 3) == 0) rf_mem[5'(ri)] = $urandom;
         if ($urandom_range(0, 3) == 0) dm_mem[3'(di)] = $urandom;
         cycle();
      end
      dump_req_i = 1'b0;
      out_ready_i = 1'b1;
      run_to_idle(200, n);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/state_dump_engine.md
STATE_DUMP_ENGINE -- requirements
Module: state_dump_engine

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of register-file words dumped.
REQ-002 SHALL have parameter NUM_MEM_WORDS, default 8, number of data-memory words dumped (byte addresses 0x00, 0x04, ...).
REQ-003 SHALL have ports (name, direction, width, meaning):
  clk_i  in  1  single clock, rising edge.
  rst_i  in  1  reset, asynchronous, active-low.
  start_i  in  1  CPU run enable; cycle counter advances only while high.
  stall_i  in  1  one stall event this cycle.
  flush_i  in  1  one flush event this cycle.
  pc_i  in  32  current PC.
  dump_req_i  in  1  request one dump record.
  rf_addr_o  out  5  register-file read address, combinational read.
  rf_data_i  in  32  register-file read data.
  dm_addr_o  out  32  data-memory byte address, combinational read.
  dm_data_i  in  32  data-memory read data.
  out_valid_o  out  1  output word valid.
  out_ready_i  in  1  sink accepts the word.
  out_data_o  out  32  output word.
  out_last_o  out  1  final word of the record.
  busy_o  out  1  dump in progress.
  overrun_o  out  1  sticky: a request was dropped.

Function
REQ-004 SHALL increment cycle_cnt on each clock while start_i=1; stall_cnt on stall_i=1; flush_cnt on flush_i=1; all 32-bit, saturating at 0xFFFFFFFF.
REQ-005 SHALL emit a record of L = 4+NUM_REGS+NUM_MEM_WORDS words (44 at defaults), index k = 0..L-1.
REQ-006 Word order: k0 cycle_cnt, k1 stall_cnt, k2 flush_cnt, k3 pc, k4..k(3+NUM_REGS) register k-4, then memory word j at byte address 4*j.
REQ-007 Words k0..k3 SHALL be snapshots latched on the cycle the request is accepted; counters continue counting during the dump.
REQ-008 Register and memory words are live reads, sampled on the edge that loads them into out_data_o.
REQ-009 FSM states: IDLE, HDR (k0..k3), REG, MEM; IDLE->HDR on dump_req_i; HDR->REG after k3 handshake; REG->MEM after last register handshake; MEM->IDLE after last word handshake.
REQ-010 Latency: dump_req_i sampled high in IDLE -> out_valid_o=1 with k0 on the next cycle.
REQ-011 out_data_o SHALL be registered; the next word's address SHALL be driven in the cycle of the current handshake so throughput is one word per cycle with no bubbles.
REQ-012 While out_valid_o=1 and out_ready_i=0, out_data_o, out_last_o, rf_addr_o and dm_addr_o SHALL hold.
REQ-013 out_last_o=1 only with word k=L-1; after its handshake, out_valid_o=0 and busy_o=0 on the next cycle.
REQ-014 busy_o=1 from the cycle after acceptance through the last handshake.
REQ-015 dump_req_i while busy_o=1, or in the cycle of the last handshake, SHALL be dropped and set overrun_o; it is never queued.
REQ-016 rf_addr_o and dm_addr_o SHALL be 0 in IDLE.

Reset
REQ-017 rst_i low SHALL asynchronously force IDLE, zero all counters and snapshots, and set out_valid_o=0, out_last_o=0, busy_o=0, overrun_o=0, out_data_o=0.
REQ-018 Reset during a dump SHALL abandon the record; no further words are produced after release until a new request.

Structure
REQ-019 Package dump_pkg SHALL hold the FSM state enum, header index constants (HDR_CYCLE=0..HDR_PC=3) and HDR_WORDS=4.
REQ-020 The three event counters SHALL be instances of one sub-module, sat_counter32 (increment enable, saturate).

Verification
REQ-021 Reset release, start_i=1 for 10 cycles, then req with ready=1 -> k0=10, out_valid_o one cycle after req.
REQ-022 RF x24=-24, x31=62, dm[0..4]=5,6,10,18,29, ready=1 -> 44 words in 44 consecutive cycles; k28=0xFFFFFFE8, k35=62, k36=5, k40=29, last only on k43.
REQ-023 ready toggled 1,0,0,1 repeatedly -> no word lost or duplicated; data and addresses stable during each stall.
REQ-024 stall_i pulsed 3 times, flush_i 2 times before req -> k1=3, k2=2; pulses during the dump do not alter emitted k1/k2.
REQ-025 Second req at word 10 -> ignored, overrun_o=1 and held, record still exactly 44 words.
REQ-026 rst_i low at word 20 -> out_valid_o=0 immediately, counters 0; a new req yields a full 44-word record.
